// File: rtl/sram_data_port.sv
// Purpose : MEM-stage data-memory responder; one 32-bit word access as two 16-bit SRAM half-accesses (low half, then high half).
// Latency : ready low for 1 + 2*PHASE_CYCLES cycles after a request appears in IDLE and high in the DONE cycle; read_data is valid from DONE.
// Backpr. : ready low freezes the pipeline; requests are taken only in IDLE, and input changes during an access are ignored.
//
// Ports:
//   clk, rst                    single clock, asynchronous active-low reset
//   rd_en, wr_en                level requests (both high => write)
//   address, write_data         byte address and store word, latched when leaving IDLE
//   read_data                   last completed read word (registered)
//   ready                       high when idle without a request, or in DONE
//   sram_addr/dq_out/dq_oe/dq_in/ce_n/oe_n/we_n   16-bit asynchronous SRAM pins
//   access_count                completed-access counter (only with SRAM_ACCESS_COUNT_EN)
//
// Optional feature: define SRAM_ACCESS_COUNT_EN to add the saturating access_count output.

module sram_data_port #(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
`ifdef SRAM_ACCESS_COUNT_EN
   ,output logic [15:0] access_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned     CNT_W    = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              op_wr_q,  op_wr_d;
    logic [15:0]       whi_q,    whi_d;
    logic [16:0]       idx_q,    idx_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic [17:0]       addr_q,   addr_d;
    logic [15:0]       dq_out_q, dq_out_d;

    // Word index relative to the SRAM window. Only the low 17 index bits
    // reach the 18-bit halfword address; higher bits simply wrap.
    logic [31:0] addr_off;
    logic        phase_last;
    logic [14:0] unused_addr_bits;

    assign addr_off         = address - BASE_ADDR;
    assign unused_addr_bits = {addr_off[31:19], addr_off[1:0]};
    assign phase_last       = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        whi_d       = whi_q;
        idx_d       = idx_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        ready       = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = ~rd_en & ~wr_en;
                if (rd_en | wr_en) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    op_wr_d = wr_en;
                    whi_d   = write_data[31:16];
                    idx_d   = addr_off[18:2];
                    // Address and low-half data are registered here so the
                    // pins are already correct in the first LO cycle.
                    addr_d  = {addr_off[18:2], 1'b0};
                    if (wr_en) begin
                        dq_out_d = write_data[15:0];
                    end
                end
            end

            ST_LO: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = op_wr_q;
                sram_we_n  = ~op_wr_q;
                sram_dq_oe = op_wr_q;
                if (phase_last) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    addr_d  = {idx_q, 1'b1};
                    if (op_wr_q) begin
                        dq_out_d = whi_q;
                    end else begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HI: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = op_wr_q;
                sram_we_n  = ~op_wr_q;
                sram_dq_oe = op_wr_q;
                if (phase_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // The pipeline advances in this cycle; a request still held
                // afterwards is a new access and is taken from IDLE.
                ready   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset returns the FSM to IDLE asynchronously, which drops every SRAM
    // control at once; the low read half captured so far is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            whi_q    <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            whi_q    <= whi_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] access_count_q, access_count_d;

    always_comb begin
        access_count_d = access_count_q;
        if (state_q == ST_DONE && access_count_q != 16'hFFFF) begin
            access_count_d = access_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            access_count_q <= '0;
        end else begin
            access_count_q <= access_count_d;
        end
    end

    assign access_count = access_count_q;
`endif

endmodule

// File: tb/tb_sram_data_port.sv
module tb_sram_data_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] access_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_data_port dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_ACCESS_COUNT_EN
       ,.access_count(access_count)
`endif
    );

    // Pin-level SRAM: fixed pseudo-random power-up contents, writes on clock.
    function automatic logic [15:0] init_half(input logic [17:0] h);
        return (h[15:0] * 16'd40503) ^ {h[17:16], 14'h1A3C};
    endfunction

    logic [15:0] sram_mem [0:262143];

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = init_half(18'(i));
    end

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

    // Word-level reference: halfwords written so far, expected read word, count.
    logic [15:0] ref_hw [logic [17:0]];
    logic [31:0] exp_rd;
    int          exp_count;

    function automatic logic [15:0] ref_half(input logic [17:0] h);
        if (ref_hw.exists(h)) return ref_hw[h];
        return init_half(h);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One access starting at the next negedge (cycle 0); returns at the
    // DONE cycle with the inputs left as they are.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input bit scramble);
        logic [31:0] off;
        logic [17:0] h0;
        logic [17:0] hk;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        off = addr - 32'd1024;
        h0  = {off[18:2], 1'b0};
        #1 check("ready_req", ready, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (scramble) begin
                rd_en = 1'($urandom); wr_en = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end
            #1;
            hk = (k <= 2) ? h0 : (h0 | 18'd1);
            check("busy_ready", ready, 0);
            check("busy_addr", sram_addr, hk);
            check("busy_ce_n", sram_ce_n, 0);
            if (wr) begin
                check("wr_we_n", sram_we_n, 0);
                check("wr_oe_n", sram_oe_n, 1);
                check("wr_dq_oe", sram_dq_oe, 1);
                check("wr_dq_out", sram_dq_out, (k <= 2) ? data[15:0] : data[31:16]);
            end else begin
                check("rd_we_n", sram_we_n, 1);
                check("rd_oe_n", sram_oe_n, 0);
                check("rd_dq_oe", sram_dq_oe, 0);
            end
        end
        if (wr) begin
            ref_hw[h0]          = data[15:0];
            ref_hw[h0 | 18'd1]  = data[31:16];
        end else begin
            exp_rd = {ref_half(h0 | 18'd1), ref_half(h0)};
        end
        if (exp_count < 65535) exp_count++;
        @(negedge clk);
        #1;
        check("done_ready", ready, 1);
        check("done_ce_n", sram_ce_n, 1);
        check("done_ctl", {sram_oe_n, sram_we_n, sram_dq_oe}, 3'b110);
        check("done_read_data", read_data, exp_rd);
        check("done_addr_hold", sram_addr, h0 | 18'd1);
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_en = 0; wr_en = 0;
            #1;
            check("idle_ready", ready, 1);
            check("idle_ce_n", sram_ce_n, 1);
            check("idle_read_data", read_data, exp_rd);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        int op;
        rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
        exp_rd = 0; exp_count = 0;
        #12;
        check("rst_ready", ready, 1);
        check("rst_read_data", read_data, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
`ifdef SRAM_ACCESS_COUNT_EN
        check("rst_count", access_count, 0);
`endif
        @(negedge clk);
        rst = 1;

        // Directed: write then read back at 1028, then rd+wr together at 1032.
        run_access(0, 1, 32'd1028, 32'hDEADBEEF, 0);
        go_idle(1);
        run_access(1, 0, 32'd1028, 32'h0, 0);
        check("read_1028", read_data, 32'hDEADBEEF);
        go_idle(1);
        run_access(1, 1, 32'd1032, 32'h12345678, 0);
        check("both_keeps_rd", read_data, 32'hDEADBEEF);
        go_idle(2);
        run_access(1, 0, 32'd1032, 32'h0, 0);
        check("read_1032", read_data, 32'h12345678);
        go_idle(1);

        // Reset pulsed during the HI phase of a read.
        @(negedge clk);
        rd_en = 1; wr_en = 0; address = 32'd1036;
        repeat (3) @(negedge clk);
        #1 rst = 0;
        #1;
        check("abort_ctl", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
        check("abort_read_data", read_data, 0);
        check("abort_sram_addr", sram_addr, 0);
        rd_en = 0;
        #1 check("abort_idle_ready", ready, 1);
        rst = 1;
        exp_rd = 0; exp_count = 0;
        run_access(1, 0, 32'd1028, 32'h0, 0);
        check("after_abort_read", read_data, 32'hDEADBEEF);

        // Back-to-back reads with rd_en held: second starts right after DONE.
        run_access(1, 0, 32'd1032, 32'h0, 0);
        run_access(1, 0, 32'd1028, 32'h0, 0);
        go_idle(1);
`ifdef SRAM_ACCESS_COUNT_EN
        check("count_three", access_count, 3);
`endif

        // Randomized accesses with random gaps and input noise mid-access.
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : (32'd1024 + $urandom_range(0, 63));
            d  = $urandom;
            run_access(op != 1, op != 0, a, d, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) go_idle($urandom_range(1, 2));
        end
        go_idle(1);

`ifdef SRAM_ACCESS_COUNT_EN
        check("count_random", access_count, 16'(exp_count));
        @(negedge clk);
        force dut.access_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.access_count_q;
        exp_count = 65535;
        run_access(1, 0, 32'd1028, 32'h0, 0);
        go_idle(1);
        check("count_saturate", access_count, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_data_port.md
# sram_data_port

Responder for the pipeline MEM stage's data-memory requests; replaces the single-cycle data memory with a multi-cycle 16-bit external SRAM. Accepts a 32-bit word read or write from the MEM stage, splits it into two 16-bit SRAM half-accesses, and holds `ready` low until the access completes. The pipeline uses `ready` to drive its global freeze. Read data is returned to the MEM/WB register path.

## Interface
- `PHASE_CYCLES`, 2: cycles per 16-bit half-access (≥1).
- `BASE_ADDR`, 1024: byte address mapped to SRAM halfword 0.
- `clk` in 1: the block's single clock.
- `rst` in 1: reset; asynchronous, active-low.
- `rd_en` in 1: MEM-stage read request (level).
- `wr_en` in 1: MEM-stage write request (level).
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: last completed read word, registered.
- `ready` out 1: high when no access is pending or the access is completing; the pipeline freezes while low.
- `sram_addr` out 18: SRAM halfword address.
- `sram_dq_out` out 16: write data to the SRAM pads.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the SRAM pads.
- `sram_ce_n` out 1: SRAM chip enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `access_count` out 16: present only with `SRAM_ACCESS_COUNT_EN`.

## Operation

**FSM states:** IDLE, LO, HI, DONE.

**IDLE**
- `rd_en|wr_en` → LO.
- Latch into internal registers at this edge: op (write if `wr_en`, else read), `write_data`, and word index = (`address` − `BASE_ADDR`) >> 2.
- Subtraction is 32-bit; `sram_addr` takes the low 18 bits of {index, phase bit}. Out-of-range addresses wrap; no error is raised.

**LO and HI**
- Each phase lasts `PHASE_CYCLES` cycles, timed by a phase counter.
- LO: `sram_addr` = {index, 0}. HI: `sram_addr` = {index, 1}.
- `sram_ce_n` = 0 throughout both phases.
- Reads: `sram_oe_n` = 0. `sram_dq_in` is captured into `read_data[15:0]` on the last LO cycle and into `read_data[31:16]` on the last HI cycle.
- Writes: `sram_we_n` = 0 and `sram_dq_oe` = 1. `sram_dq_out` = `write_data[15:0]` in LO and `[31:16]` in HI.

**DONE**
- One cycle, then → IDLE.

**`ready`** (combinational)
- `ready` = (IDLE & ~`rd_en` & ~`wr_en`) | DONE.

**Input handling**
- `rd_en` and `wr_en` together: the access is a write.
- Input changes after the IDLE→LO edge are ignored until IDLE is reached again.
- A request still asserted in IDLE after DONE starts a new access. This is the normal back-to-back case: the pipeline advanced during DONE.

**Idle outputs**
- In IDLE and DONE: all SRAM controls are inactive (`ce_n`, `oe_n`, `we_n` = 1; `dq_oe` = 0).
- `sram_addr` holds its last value.

## Timing

**Reset values** (async, `rst` low)
- FSM → IDLE, phase counter 0.
- `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
- `sram_dq_oe` = 0; `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
- `ready` = 1 when no request is present.
- `access_count` = 0.

**Reset mid-access**
- Aborts immediately: SRAM controls deassert asynchronously and no `read_data` update occurs.
- A partially written SRAM word is acceptable.

**Latency**
- Request present in cycle 0 (IDLE): `ready` is low for 1 + 2·`PHASE_CYCLES` cycles and high in the DONE cycle.
- With default `PHASE_CYCLES` = 2: `ready` is low in cycles 0–4 and high in cycle 5.
- `read_data` is valid from the DONE cycle and is held until the next read completes.
- Writes never modify `read_data`.

**Back-to-back**
- Minimum spacing is 2·`PHASE_CYCLES` + 2 cycles per access.

## Configuration
- `SRAM_ACCESS_COUNT_EN` defined:
  - `access_count` output exists.
  - It increments by 1 in every DONE cycle (reads and writes) and saturates at 0xFFFF.
  - Cleared only by reset.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Write `address` = 1028, `write_data` = 0xDEADBEEF, defaults:
  - `sram_addr` = 2 with `dq_out` = 0xBEEF for 2 cycles, then `sram_addr` = 3 with `dq_out` = 0xDEAD for 2 cycles.
  - `we_n` low throughout; `ready` low for 5 cycles, then high.
- Read `address` = 1028 against an SRAM model holding the previous write:
  - `read_data` = 0xDEADBEEF in the DONE cycle.
  - `oe_n` low and `we_n` high throughout.
- `rd_en` = `wr_en` = 1, `address` = 1032, data 0x12345678:
  - A write occurs at halfwords 4/5 and `read_data` is unchanged.
  - Follow-up read returns 0x12345678.
- `rst` pulsed low during the HI phase of a read:
  - All SRAM controls go inactive immediately.
  - `read_data` = 0; FSM in IDLE.
  - Next request completes normally.
- Two reads held back-to-back (`rd_en` stays high, address changes at DONE):
  - Second access starts the cycle after DONE.
  - `ready` pattern repeats with 6-cycle spacing.
- With `SRAM_ACCESS_COUNT_EN`:
  - 3 accesses → `access_count` = 3.
  - Preload to 0xFFFF via forced state, one more access → stays 0xFFFF.
